// File: rtl/sram_burst_controller_pkg.sv
// sram_burst_controller_pkg: shared constants and FSM encoding for the burst SRAM controller.
package sram_burst_controller_pkg;
    localparam int SRAM_DATA_BUS = 16;
    localparam logic SRAM_ENABLE = 1'b0;
    localparam logic SRAM_DISABLE = 1'b1;
    localparam logic ENABLE = 1'b1;
    localparam logic DISABLE = 1'b0;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/sram_burst_controller_if.sv
// sram_burst_controller_if: CPU-side memory-stage bus of the burst SRAM controller.
interface sram_burst_controller_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic read_enable;
    logic write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] write_data;
    logic [WORD_WIDTH/8-1:0] byte_en;
    logic [WORD_WIDTH-1:0] read_data;
    logic ready;
    logic error;
    modport master (
        output read_enable, write_enable, address, write_data, byte_en,
        input read_data, ready, error
    );
    modport slave (
        input read_enable, write_enable, address, write_data, byte_en,
        output read_data, ready, error
    );
endinterface

// File: rtl/sram_beat_counter.sv
// sram_beat_counter: beat index and per-beat cycle counter; wraps to zero after the last beat.
module sram_beat_counter #(
    parameter int BEATS = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int BW = $clog2(BEATS),
    parameter int CW = $clog2(WAIT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clear,
    output logic [BW-1:0] beat,
    output logic [CW-1:0] cyc,
    output logic          beat_last_cycle,
    output logic          last
);
    assign beat_last_cycle = cyc == CW'(WAIT_CYCLES);
    assign last = beat_last_cycle && beat == BW'(BEATS - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            beat <= '0;
            cyc  <= '0;
        end else if (clear) begin
            beat <= '0;
            cyc  <= '0;
        end else if (run) begin
            cyc  <= beat_last_cycle ? '0 : cyc + CW'(1);
            beat <= last ? '0 : beat + BW'(beat_last_cycle);
        end
endmodule

// File: rtl/sram_burst_controller.sv
// sram_burst_controller: maps one CPU word access onto BEATS 16-bit SRAM accesses
// with wait states, byte-lane masking and out-of-range rejection.
module sram_burst_controller
    import sram_burst_controller_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int BASE_ADDR = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_burst_controller_if.slave     bus,
    inout  wire  [SRAM_DATA_BUS-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_OE_N
);
    localparam int BEATS = WORD_WIDTH / 16;
    localparam int WORD_BYTES = WORD_WIDTH / 8;
    localparam int LG = $clog2(WORD_BYTES);
    localparam int BW = $clog2(BEATS);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_t state, ns;
    logic [BW-1:0] beat, beat_n;
    logic [CW-1:0] cyc, cyc_n;
    logic blc, last, busy, req, in_range, dq_oe;
    logic [1:0] lanes;
    logic [SRAM_DATA_BUS-1:0] dq_q;
    logic [WORD_WIDTH-1:0] rd_q;
    logic err_q;
    logic [ADDR_WIDTH-1:0] off, idx;
    logic [ADDR_WIDTH+1:0] first_word, last_word;

    sram_beat_counter #(.BEATS(BEATS), .WAIT_CYCLES(WAIT_CYCLES), .BW(BW), .CW(CW)) u_cnt (
        .clk(clk), .rst(rst), .run(busy), .clear(!busy),
        .beat(beat), .cyc(cyc), .beat_last_cycle(blc), .last(last)
    );

    assign req = bus.read_enable | bus.write_enable;
    assign busy = state == READ || state == WRITE;
    assign off = bus.address - ADDR_WIDTH'(BASE_ADDR);
    assign idx = off >> LG;
    assign first_word = {2'b00, idx} << BW;
    assign last_word = first_word + (ADDR_WIDTH + 2)'(BEATS - 1);
    assign in_range = bus.address >= ADDR_WIDTH'(BASE_ADDR) && (last_word >> SRAM_ADDR_WIDTH) == '0;
    // Beat 0 carries the most significant half-word, so lanes are taken from the top down.
    assign lanes = bus.byte_en[2*(BEATS-1-int'(beat_n)) +: 2];
    assign SRAM_DQ = dq_oe ? dq_q : 'z;
    assign bus.ready = state == DONE || (state == IDLE && !req);
    assign bus.read_data = rd_q;
    assign bus.error = err_q;

    always_comb ns = state == DONE ? IDLE
                   : busy ? (last ? DONE : state)
                   : !req ? IDLE
                   : bus.read_enable ? (in_range ? READ : DONE)
                   : (in_range && |bus.byte_en) ? WRITE : DONE;

    // Counter lookahead lets the SRAM pins be registered against the next state.
    always_comb begin
        beat_n = (!busy || last) ? '0 : beat + BW'(blc);
        cyc_n  = (!busy || blc) ? '0 : cyc + CW'(1);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            rd_q      <= '0;
            err_q     <= 1'b0;
            dq_oe     <= DISABLE;
            dq_q      <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= SRAM_DISABLE;
            SRAM_CE_N <= SRAM_DISABLE;
            SRAM_OE_N <= SRAM_DISABLE;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
        end else begin
            state     <= ns;
            err_q     <= state == IDLE && req && !in_range;
            SRAM_CE_N <= (ns == READ || ns == WRITE) ? SRAM_ENABLE : SRAM_DISABLE;
            SRAM_OE_N <= ns == READ ? SRAM_ENABLE : SRAM_DISABLE;
            SRAM_WE_N <= (ns == WRITE && cyc_n != '0 && lanes != 2'b00) ? SRAM_ENABLE : SRAM_DISABLE;
            {SRAM_UB_N, SRAM_LB_N} <= ns == WRITE ? ~lanes : 2'b00;
            dq_oe     <= ns == WRITE ? ENABLE : DISABLE;
            dq_q      <= bus.write_data[16*(BEATS-1-int'(beat_n)) +: 16];
            if (ns == READ || ns == WRITE)
                SRAM_ADDR <= first_word[SRAM_ADDR_WIDTH-1:0] + SRAM_ADDR_WIDTH'(beat_n);
            if (state == READ && blc)
                rd_q[16*(BEATS-1-int'(beat)) +: 16] <= SRAM_DQ;
        end
endmodule

// File: tb/tb_sram_burst_controller.sv
// tb_sram_burst_controller: scoreboard bench for the 32-bit/1-wait and 64-bit/3-wait controllers
// against behavioural 16-bit SRAM models.
module tb_sram_burst_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit err;
        int lat;
        logic [63:0] data;
    } exp_t;
    exp_t q32[$];
    exp_t q64[$];

    sram_burst_controller_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32)) b32 ();
    sram_burst_controller_if #(.WORD_WIDTH(64), .ADDR_WIDTH(32)) b64 ();

    wire [15:0] dq32, dq64;
    logic [17:0] a32, a64;
    logic ub32, lb32, we32, ce32, oe32;
    logic ub64, lb64, we64, ce64, oe64;

    sram_burst_controller #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(18),
                            .BASE_ADDR(1024), .WAIT_CYCLES(1)) d32 (
        .clk(clk), .rst(rst), .bus(b32), .SRAM_DQ(dq32), .SRAM_ADDR(a32),
        .SRAM_UB_N(ub32), .SRAM_LB_N(lb32), .SRAM_WE_N(we32), .SRAM_CE_N(ce32), .SRAM_OE_N(oe32)
    );
    sram_burst_controller #(.WORD_WIDTH(64), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(18),
                            .BASE_ADDR(1024), .WAIT_CYCLES(3)) d64 (
        .clk(clk), .rst(rst), .bus(b64), .SRAM_DQ(dq64), .SRAM_ADDR(a64),
        .SRAM_UB_N(ub64), .SRAM_LB_N(lb64), .SRAM_WE_N(we64), .SRAM_CE_N(ce64), .SRAM_OE_N(oe64)
    );

    // SRAM models: asynchronous read while CE/OE low, write sampled mid-cycle while WE low.
    logic [15:0] m32 [16];
    logic [15:0] m64 [16];
    int wc32 [16];
    int wc64 [16];
    int oec32 = 0;
    bit ces32 = 1'b0;
    logic lub32, llb32;

    assign dq32 = (!ce32 && !oe32) ? m32[a32[3:0]] : 16'hzzzz;
    assign dq64 = (!ce64 && !oe64) ? m64[a64[3:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce32) ces32 = 1'b1;
        if (!ce32 && !oe32) oec32++;
        if (!ce32 && !we32) begin
            if (!lb32) m32[a32[3:0]][7:0] = dq32[7:0];
            if (!ub32) m32[a32[3:0]][15:8] = dq32[15:8];
            wc32[a32[3:0]]++;
            lub32 = ub32;
            llb32 = lb32;
        end
        if (!ce64 && !we64) begin
            if (!lb64) m64[a64[3:0]][7:0] = dq64[7:0];
            if (!ub64) m64[a64[3:0]][15:8] = dq64[15:8];
            wc64[a64[3:0]]++;
        end
    end

    task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // Monitors: a request seen with ready=1 is the DONE cycle; pop and compare its response.
    int cnt32 = 0, cnt64 = 0;
    bit post32 = 1'b0, post64 = 1'b0;
    exp_t e32, e64;

    always @(negedge clk) begin
        if (post32) begin
            post32 = 1'b0;
            check({e32.name, "_err_after"}, {63'h0, b32.error}, 64'h0);
            check({e32.name, "_rdata_after"}, {32'h0, b32.read_data}, e32.data);
        end
        if (b32.read_enable || b32.write_enable) begin
            if (!b32.ready) cnt32++;
            else begin
                if (q32.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d32_unexpected: response with empty scoreboard");
                end else begin
                    e32 = q32.pop_front();
                    check({e32.name, "_latency"}, 64'(cnt32), 64'(e32.lat));
                    check({e32.name, "_err"}, {63'h0, b32.error}, {63'h0, e32.err});
                    check({e32.name, "_rdata"}, {32'h0, b32.read_data}, e32.data);
                    post32 = 1'b1;
                end
                cnt32 = 0;
            end
        end else cnt32 = 0;
    end

    always @(negedge clk) begin
        if (post64) begin
            post64 = 1'b0;
            check({e64.name, "_err_after"}, {63'h0, b64.error}, 64'h0);
            check({e64.name, "_rdata_after"}, b64.read_data, e64.data);
        end
        if (b64.read_enable || b64.write_enable) begin
            if (!b64.ready) cnt64++;
            else begin
                if (q64.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL d64_unexpected: response with empty scoreboard");
                end else begin
                    e64 = q64.pop_front();
                    check({e64.name, "_latency"}, 64'(cnt64), 64'(e64.lat));
                    check({e64.name, "_err"}, {63'h0, b64.error}, {63'h0, e64.err});
                    check({e64.name, "_rdata"}, b64.read_data, e64.data);
                    post64 = 1'b1;
                end
                cnt64 = 0;
            end
        end else cnt64 = 0;
    end

    task automatic acc32(input string n, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input bit err,
                         input int lat, input logic [31:0] exp_rd);
        int k;
        q32.push_back('{n, err, lat, {32'h0, exp_rd}});
        @(posedge clk);
        #1;
        b32.read_enable = rd;
        b32.write_enable = wr;
        b32.address = a;
        b32.write_data = wd;
        b32.byte_en = be;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (b32.ready) break;
            k++;
        end
        if (k == 100) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: ready never rose within 100 cycles", n);
        end
        @(posedge clk);
        #1;
        b32.read_enable = 1'b0;
        b32.write_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic acc64(input string n, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [63:0] wd, input logic [7:0] be, input bit err,
                         input int lat, input logic [63:0] exp_rd);
        int k;
        q64.push_back('{n, err, lat, exp_rd});
        @(posedge clk);
        #1;
        b64.read_enable = rd;
        b64.write_enable = wr;
        b64.address = a;
        b64.write_data = wd;
        b64.byte_en = be;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (b64.ready) break;
            k++;
        end
        if (k == 100) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: ready never rose within 100 cycles", n);
        end
        @(posedge clk);
        #1;
        b64.read_enable = 1'b0;
        b64.write_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m32[i] = 16'(i * 257);
            m64[i] = 16'h0;
            wc32[i] = 0;
            wc64[i] = 0;
        end
        {b32.read_enable, b32.write_enable, b32.address, b32.write_data, b32.byte_en} = '0;
        {b64.read_enable, b64.write_enable, b64.address, b64.write_data, b64.byte_en} = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {61'h0, ce32, oe32, we32}, 64'h7);
        check("rst_lanes", {62'h0, ub32, lb32}, 64'h0);
        check("rst_addr", 64'(a32), 64'h0);
        check("rst_rdata", {32'h0, b32.read_data}, 64'h0);
        check("rst_err", {63'h0, b32.error}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {63'h0, b32.ready}, 64'h1);

        acc32("wr_full", 1'b0, 1'b1, 1028, 32'hDEADBEEF, 4'hF, 1'b0, 5, 32'h0);
        check("wr_full_m2", 64'(m32[2]), 64'hDEAD);
        check("wr_full_m3", 64'(m32[3]), 64'hBEEF);
        check("wr_full_we2", 64'(wc32[2]), 64'd1);
        check("wr_full_we3", 64'(wc32[3]), 64'd1);
        check("wr_full_oe", 64'(oec32), 64'd0);

        acc32("rd_full", 1'b1, 1'b0, 1028, 32'h0, 4'h0, 1'b0, 5, 32'hDEADBEEF);
        check("rd_full_oe", 64'(oec32), 64'd4);

        acc32("wr_lane", 1'b0, 1'b1, 1028, 32'h11223344, 4'b0100, 1'b0, 5, 32'hDEADBEEF);
        check("wr_lane_m2", 64'(m32[2]), 64'hDE22);
        check("wr_lane_m3", 64'(m32[3]), 64'hBEEF);
        check("wr_lane_we2", 64'(wc32[2]), 64'd2);
        check("wr_lane_we3", 64'(wc32[3]), 64'd1);
        check("wr_lane_ublb", {62'h0, lub32, llb32}, 64'h2);

        acc32("rd_lane", 1'b1, 1'b0, 1028, 32'h0, 4'h0, 1'b0, 5, 32'hDE22BEEF);

        ces32 = 1'b0;
        acc32("rd_low", 1'b1, 1'b0, 1020, 32'h0, 4'h0, 1'b1, 1, 32'hDE22BEEF);
        check("rd_low_ce", {63'h0, ces32}, 64'h0);
        acc32("wr_high", 1'b0, 1'b1, 525312, 32'hA5A5A5A5, 4'hF, 1'b1, 1, 32'hDE22BEEF);
        check("wr_high_ce", {63'h0, ces32}, 64'h0);
        acc32("wr_mask0", 1'b0, 1'b1, 1028, 32'hFFFFFFFF, 4'h0, 1'b0, 1, 32'hDE22BEEF);
        check("wr_mask0_ce", {63'h0, ces32}, 64'h0);
        check("wr_mask0_m2", 64'(m32[2]), 64'hDE22);

        acc32("rd_top", 1'b1, 1'b0, 525308, 32'h0, 4'h0, 1'b0, 5, 32'h0E0E0F0F);

        acc32("rd_prio", 1'b1, 1'b1, 1028, 32'h55555555, 4'hF, 1'b0, 5, 32'hDE22BEEF);
        check("rd_prio_we2", 64'(wc32[2]), 64'd2);
        check("rd_prio_m3", 64'(m32[3]), 64'hBEEF);

        acc64("wr64", 1'b0, 1'b1, 1024, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 17, 64'h0);
        check("wr64_m0", 64'(m64[0]), 64'h0123);
        check("wr64_m1", 64'(m64[1]), 64'h4567);
        check("wr64_m2", 64'(m64[2]), 64'h89AB);
        check("wr64_m3", 64'(m64[3]), 64'hCDEF);
        for (int i = 0; i < 4; i++) check("wr64_we", 64'(wc64[i]), 64'd3);
        acc64("rd64", 1'b1, 1'b0, 1024, 64'h0, 8'h0, 1'b0, 17, 64'h0123456789ABCDEF);

        @(posedge clk);
        #1;
        b32.write_enable = 1'b1;
        b32.address = 1028;
        b32.write_data = 32'hCAFEF00D;
        b32.byte_en = 4'hF;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ctrl", {61'h0, ce32, oe32, we32}, 64'h7);
        check("abort_lanes", {62'h0, ub32, lb32}, 64'h0);
        check("abort_addr", 64'(a32), 64'h0);
        check("abort_rdata", {32'h0, b32.read_data}, 64'h0);
        b32.write_enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {63'h0, b32.ready}, 64'h1);
        check("abort_m2", 64'(m32[2]), 64'hDE22);
        check("abort_m3", 64'(m32[3]), 64'hBEEF);
        check("abort_we2", 64'(wc32[2]), 64'd2);
        check("abort_we3", 64'(wc32[3]), 64'd1);
        check("sb_drained", 64'(q32.size() + q64.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
